// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: sequencer state encoding and shared widths for the PLL reset sequencer.
package pll_rst_pkg;
    typedef enum logic [2:0] {S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL} state_t;
    localparam int RELOCK_W = 8;
endpackage

// File: rtl/bit_sync_2ff.sv
// bit_sync_2ff: two-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module bit_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL in reset, waits for a debounced lock with timeout and retries,
// then releases sys_rst_n; re-sequences on lock loss or soft_reset.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                refclk,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic                soft_reset,
    output logic                pll_rst,
    output logic                sys_rst_n,
    output logic                ready,
    output logic                lock_fail,
    output logic [RELOCK_W-1:0] relock_count
);
    localparam int MAX_AB = RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAXC   = MAX_AB > LOCK_STABLE_CYCLES ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int RW     = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [CW-1:0] HOLD_END   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TMO_END    = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_END = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    state_t              state, nxt;
    logic [CW-1:0]       cnt;
    logic [RW-1:0]       retry, retry_nxt;
    logic [RELOCK_W-1:0] relock_nxt;
    logic                lock_s;

    bit_sync_2ff u_lock_sync (
        .clk    (refclk),
        .reset_n(reset_n),
        .d      (pll_locked),
        .q      (lock_s)
    );

    always_comb begin
        nxt        = state;
        retry_nxt  = retry;
        relock_nxt = relock_count;
        case (state)
            S_RESET:     nxt = cnt == HOLD_END ? S_WAIT_LOCK : S_RESET;
            S_WAIT_LOCK:
                if (lock_s) nxt = S_STABLE;
                else if (cnt == TMO_END) begin
                    nxt       = retry < RETRY_MAX ? S_RESET : S_FAIL;
                    retry_nxt = retry < RETRY_MAX ? retry + RW'(1) : retry;
                end
            S_STABLE:
                if (!lock_s) nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_END) begin
                    nxt       = S_RUN;
                    retry_nxt = '0;
                end
            S_RUN:
                if (!lock_s) begin
                    nxt        = S_RESET;
                    relock_nxt = &relock_count ? relock_count : relock_count + RELOCK_W'(1);
                end
            S_FAIL:      nxt = S_FAIL;
            default:     nxt = S_RESET;
        endcase
        // soft_reset wins over everything, including a simultaneous lock loss in S_RUN
        if (soft_reset) begin
            nxt        = S_RESET;
            retry_nxt  = '0;
            relock_nxt = relock_count;
        end
    end

    always_ff @(posedge refclk or negedge reset_n)
        if (!reset_n) begin
            state        <= S_RESET;
            cnt          <= '0;
            retry        <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
            lock_fail    <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= (soft_reset || nxt != state) ? '0 : cnt + CW'(1);
            retry        <= retry_nxt;
            relock_count <= relock_nxt;
            pll_rst      <= nxt == S_RESET || nxt == S_FAIL;
            sys_rst_n    <= nxt == S_RUN;
            ready        <= nxt == S_RUN;
            lock_fail    <= nxt == S_FAIL;
        end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench; a phase/dwell reference model predicts outputs per refclk edge.
module tb_pll_reset_sequencer;
    localparam int HOLD = 4, TMO = 20, STB = 8, RETRY = 2;

    typedef struct packed {
        logic       rst;
        logic       sys;
        logic       rdy;
        logic       fail;
        logic [7:0] cnt;
    } exp_t;

    logic       refclk = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, soft_reset = 1'b0;
    logic       pll_rst, sys_rst_n, ready, lock_fail;
    logic [7:0] relock_count;

    int    total = 0, bad = 0, cyc = 0, first_ready = -1;
    exp_t  q[$];
    exp_t  e;
    string ph;
    int    dwell, tries, relocks;
    bit    hist[$];

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .LOCK_STABLE_CYCLES (STB),
        .MAX_RETRIES        (RETRY)
    ) dut (
        .refclk      (refclk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .soft_reset  (soft_reset),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .lock_fail   (lock_fail),
        .relock_count(relock_count)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        ph      = "RESET";
        dwell   = 0;
        tries   = 0;
        relocks = 0;
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endtask

    task automatic enter(input string p);
        ph    = p;
        dwell = 0;
    endtask

    // One refclk edge of the reference: lk/sr are the inputs sampled at that edge.
    task automatic model_edge(input bit lk, input bit sr);
        bit ls;
        ls = hist.pop_front();
        hist.push_back(lk);
        dwell++;
        if (sr) begin
            enter("RESET");
            tries = 0;
        end else if (ph == "RESET") begin
            if (dwell == HOLD) enter("WAIT");
        end else if (ph == "WAIT") begin
            if (ls) enter("STABLE");
            else if (dwell == TMO) begin
                if (tries < RETRY) begin
                    tries++;
                    enter("RESET");
                end else enter("FAIL");
            end
        end else if (ph == "STABLE") begin
            if (!ls) enter("WAIT");
            else if (dwell == STB) begin
                tries = 0;
                enter("RUN");
            end
        end else if (ph == "RUN" && !ls) begin
            relocks = relocks < 255 ? relocks + 1 : 255;
            enter("RESET");
        end
        q.push_back('{ph == "RESET" || ph == "FAIL", ph == "RUN", ph == "RUN", ph == "FAIL", 8'(relocks)});
    endtask

    task automatic drive(input bit lk, input bit sr);
        pll_locked = lk;
        soft_reset = sr;
        model_edge(lk, sr);
    endtask

    task automatic step(input bit lk, input bit sr);
        @(negedge refclk);
        drive(lk, sr);
    endtask

    task automatic release_reset(input bit lk);
        @(negedge refclk);
        reset_n = 1'b1;
        model_reset();
        cyc = 0;
        drive(lk, 1'b0);
    endtask

    // Monitor: every edge outside reset presents one output word to compare.
    initial forever begin
        @(posedge refclk);
        #5;
        if (reset_n && q.size() > 0) begin
            e = q.pop_front();
            cyc++;
            chk($sformatf("sb_cyc%0d", cyc), int'({pll_rst, sys_rst_n, ready, lock_fail, relock_count}), int'(e));
            if (ready && first_ready < 0) first_ready = cyc;
        end
    end

    initial begin
        int lvl, n;
        #25;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_lock_fail", lock_fail, 0);
        chk("rst_relock", relock_count, 0);
        // normal start: lock rises at cycle 10
        release_reset(1'b0);
        repeat (9) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        chk("s1_ready_cycle", first_ready, 21);
        chk("s1_relock", relock_count, 0);
        // debounce glitch after 5 stable cycles
        step(1'b1, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        chk("s2_ready", ready, 1);
        // lock loss in RUN
        repeat (3) step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        chk("s3_relock", relock_count, 1);
        chk("s3_ready", ready, 1);
        // soft_reset coinciding with lock loss
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        chk("prio_relock", relock_count, 1);
        repeat (4) begin
            step(1'b0, 1'b0);
            repeat (19) step(1'b1, 1'b0);
        end
        chk("s5_pre_relock", relock_count, 5);
        // async reset mid-RUN, checked before the next edge
        @(posedge refclk);
        #3;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("s5_pll_rst", pll_rst, 1);
        chk("s5_sys_rst_n", sys_rst_n, 0);
        chk("s5_ready", ready, 0);
        chk("s5_relock", relock_count, 0);
        // never lock
        release_reset(1'b0);
        repeat (80) step(1'b0, 1'b0);
        chk("s4_lock_fail", lock_fail, 1);
        chk("s4_pll_rst", pll_rst, 1);
        chk("s4_sys_rst_n", sys_rst_n, 0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        chk("s4_soft_lock_fail", lock_fail, 0);
        chk("s4_soft_pll_rst", pll_rst, 1);
        repeat (2) step(1'b0, 1'b0);
        chk("s4_pulse_end", pll_rst, 0);
        // random lock levels with occasional soft_reset
        repeat (60) begin
            lvl = $urandom_range(0, 1);
            n   = $urandom_range(1, 40);
            repeat (n) step(lvl[0], $urandom_range(0, 49) == 0);
        end
        // saturation
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        repeat (260) begin
            step(1'b0, 1'b0);
            repeat (17) step(1'b1, 1'b0);
        end
        chk("s6_saturate", relock_count, 255);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b0);
        chk("s6_prio_relock", relock_count, 255);
        chk("s6_ready", ready, 1);
        @(posedge refclk);
        #8;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
